// File: rtl/ref_frame_streamer_if.sv
// Signal bundle for ref_frame_streamer: camera tap, reference stream master and frame RAM port.
// The DUT takes the master modport; the environment (aligner, RAM, camera) takes the slave modport.
interface ref_frame_streamer_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 19
) ();
   logic [DATA_W-1:0] cam_tdata;
   logic              cam_tvalid;
   logic              cam_tready;
   logic              cam_tuser;
   logic [DATA_W-1:0] m_ref_tdata;
   logic              m_ref_tvalid;
   logic              m_ref_tuser;
   logic              m_ref_tlast;
   logic              m_ref_tready;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  cam_tdata, cam_tvalid, cam_tready, cam_tuser,
      output m_ref_tdata, m_ref_tvalid, m_ref_tuser, m_ref_tlast,
      input  m_ref_tready,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport slave (
      output cam_tdata, cam_tvalid, cam_tready, cam_tuser,
      input  m_ref_tdata, m_ref_tvalid, m_ref_tuser, m_ref_tlast,
      output m_ref_tready,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/ref_frame_streamer.sv
// Captures one camera frame into an external single-port RAM as background, then replays it
// continuously as a backpressure-aware stream (tuser = SOF, tlast = end of line).
module ref_frame_streamer #(
   parameter int DATA_W = 16,
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 enable,
   input  logic                 capture_req,
   ref_frame_streamer_if.master bus,
   output logic                 ref_valid,
   output logic                 capturing
);
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);
   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(H_RES - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, STREAM} state_t;

   state_t            state_q, state_d;
   logic              ref_valid_q, ref_valid_d;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic              vld_p1_q, vld_p1_d;
   logic              user_p1_q, user_p1_d;
   logic              last_p1_q, last_p1_d;
   logic              eof_p1_q, eof_p1_d;
   logic [DATA_W-1:0] fdata_q [2];
   logic [DATA_W-1:0] fdata_d [2];
   logic [2:0]        fflag_q [2];
   logic [2:0]        fflag_d [2];
   logic              wp_q, wp_d, rp_q, rp_d;
   logic [1:0]        cnt_q, cnt_d;

   logic              cam_fire, ref_fire, frame_end, leave, issue, wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [1:0]        occ;

   assign cam_fire  = bus.cam_tvalid & bus.cam_tready;
   assign ref_fire  = (cnt_q != 2'd0) & bus.m_ref_tready;
   assign frame_end = (state_q == STREAM) & ref_fire & fflag_q[rp_q][2];
   assign leave     = frame_end & (pend_q | capture_req | !enable);
   assign occ       = cnt_q + {1'b0, vld_p1_q};
   // Counting the slot freed by this cycle's pop keeps the 2-entry FIFO at one pixel per cycle.
   assign issue     = (state_q == STREAM) & !leave & ((occ < 2'd2) | ref_fire);
   assign wr_en     = cam_fire & (((state_q == WAIT_SOF) & bus.cam_tuser) | (state_q == CAPTURE));
   assign wr_addr   = bus.cam_tuser ? '0 : wr_ptr_q;

   assign bus.mem_en       = wr_en | issue;
   assign bus.mem_we       = wr_en;
   assign bus.mem_addr     = wr_en ? wr_addr : (issue ? rd_ptr_q : '0);
   assign bus.mem_wdata    = wr_en ? bus.cam_tdata : '0;
   assign bus.m_ref_tvalid = (cnt_q != 2'd0);
   assign bus.m_ref_tdata  = fdata_q[rp_q];
   assign bus.m_ref_tuser  = fflag_q[rp_q][0];
   assign bus.m_ref_tlast  = fflag_q[rp_q][1];
   assign ref_valid        = ref_valid_q;
   assign capturing        = (state_q == WAIT_SOF) || (state_q == CAPTURE);

   always_comb begin
      state_d     = state_q;
      ref_valid_d = ref_valid_q;
      pend_d      = pend_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      col_d       = col_q;
      vld_p1_d    = issue;
      user_p1_d   = (rd_ptr_q == '0);
      last_p1_d   = (col_q == LAST_COL);
      eof_p1_d    = (rd_ptr_q == LAST_PIX);
      fdata_d     = fdata_q;
      fflag_d     = fflag_q;
      wp_d        = wp_q;
      rp_d        = rp_q;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            if (capture_req) begin
               state_d     = WAIT_SOF;
               ref_valid_d = 1'b0;
            end else if (ref_valid_q && enable) begin
               state_d = STREAM;
            end
         end
         WAIT_SOF: begin
            if (wr_en) begin
               state_d  = CAPTURE;
               wr_ptr_d = ADDR_ONE;
            end
         end
         CAPTURE: begin
            if (wr_en) begin
               if (bus.cam_tuser) begin
                  wr_ptr_d = ADDR_ONE;
               end else if (wr_ptr_q == LAST_PIX) begin
                  ref_valid_d = 1'b1;
                  wr_ptr_d    = '0;
                  state_d     = enable ? STREAM : IDLE;
               end else begin
                  wr_ptr_d = wr_ptr_q + ADDR_ONE;
               end
            end
         end
         STREAM: begin
            if (capture_req) pend_d = 1'b1;
            if (leave) begin
               pend_d = 1'b0;
               if (pend_q || capture_req) begin
                  state_d     = WAIT_SOF;
                  ref_valid_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Stage p0 -> p1: issue address and its frame markers
      if (issue) begin
         rd_ptr_d = (rd_ptr_q == LAST_PIX) ? '0 : rd_ptr_q + ADDR_ONE;
         col_d    = (col_q == LAST_COL) ? '0 : col_q + ADDR_ONE;
      end

      // Stage p1 -> FIFO: RAM data joins its markers
      if (vld_p1_q) begin
         fdata_d[wp_q] = bus.mem_rdata;
         fflag_d[wp_q] = {eof_p1_q, last_p1_q, user_p1_q};
         wp_d          = ~wp_q;
      end
      if (ref_fire) rp_d = ~rp_q;
      case ({vld_p1_q, ref_fire})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase

      // Leaving STREAM drops any prefetched pixels and in-flight reads.
      if (state_d != STREAM) begin
         rd_ptr_d = '0;
         col_d    = '0;
         vld_p1_d = 1'b0;
         wp_d     = 1'b0;
         rp_d     = 1'b0;
         cnt_d    = 2'd0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         ref_valid_q <= 1'b0;
         pend_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         col_q       <= '0;
         vld_p1_q    <= 1'b0;
         user_p1_q   <= 1'b0;
         last_p1_q   <= 1'b0;
         eof_p1_q    <= 1'b0;
         fdata_q     <= '{default: '0};
         fflag_q     <= '{default: '0};
         wp_q        <= 1'b0;
         rp_q        <= 1'b0;
         cnt_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         ref_valid_q <= ref_valid_d;
         pend_q      <= pend_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         col_q       <= col_d;
         vld_p1_q    <= vld_p1_d;
         user_p1_q   <= user_p1_d;
         last_p1_q   <= last_p1_d;
         eof_p1_q    <= eof_p1_d;
         fdata_q     <= fdata_d;
         fflag_q     <= fflag_d;
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         cnt_q       <= cnt_d;
      end
   end
endmodule

// File: tb/tb_ref_frame_streamer.sv
// Directed bench for ref_frame_streamer on a 4x3 frame with a behavioural 1-cycle RAM.
module tb_ref_frame_streamer;
   localparam int DW = 16;
   localparam int HR = 4;
   localparam int VR = 3;
   localparam int AW = 4;
   localparam int FR = HR * VR;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic enable = 1'b0;
   logic capture_req = 1'b0;
   logic ref_valid, capturing;
   int   checks = 0;
   int   errors = 0;
   int   exp_idx = 0;
   logic [DW-1:0] ram [16];

   ref_frame_streamer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   ref_frame_streamer #(.DATA_W(DW), .H_RES(HR), .V_RES(VR), .ADDR_W(AW)) dut (
      .aclk(aclk), .aresetn(aresetn), .enable(enable), .capture_req(capture_req),
      .bus(bus), .ref_valid(ref_valid), .capturing(capturing)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata <= ram[bus.mem_addr];
      end
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive_cam(input logic [DW-1:0] v, input logic sof);
      bus.cam_tdata  = v;
      bus.cam_tvalid = 1'b1;
      bus.cam_tready = 1'b1;
      bus.cam_tuser  = sof;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge aclk);
      #1;
      checks++;
      if ({bus.m_ref_tvalid, bus.m_ref_tuser, bus.m_ref_tlast} !== 3'b000) begin
         errors++; $display("FAIL reset_stream_flags: got %b expected 000", {bus.m_ref_tvalid, bus.m_ref_tuser, bus.m_ref_tlast});
      end
      checks++;
      if (bus.m_ref_tdata !== 16'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", bus.m_ref_tdata); end
      checks++;
      if ({ref_valid, capturing} !== 2'b00) begin errors++; $display("FAIL reset_status: got %b expected 00", {ref_valid, capturing}); end
      checks++;
      if ({bus.mem_en, bus.mem_we} !== 2'b00 || bus.mem_addr !== 4'h0) begin
         errors++; $display("FAIL reset_mem: got en/we %b addr %h expected 00 / 0", {bus.mem_en, bus.mem_we}, bus.mem_addr);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      step();
   endtask

   task automatic test_capture();
      enable = 1'b0;
      capture_req = 1'b1;
      step();
      capture_req = 1'b0;
      checks++;
      if ({capturing, ref_valid} !== 2'b10) begin errors++; $display("FAIL capture_wait_sof: got cap/rv %b expected 10", {capturing, ref_valid}); end
      for (int i = 0; i < FR; i++) begin
         if (i == FR - 1) begin
            checks++;
            if (ref_valid !== 1'b0) begin errors++; $display("FAIL capture_ref_valid_early: got %b expected 0", ref_valid); end
         end
         drive_cam(DW'(i), i == 0);
         #1;
         checks++;
         if ({bus.mem_en, bus.mem_we} !== 2'b11 || bus.mem_addr !== AW'(i) || bus.mem_wdata !== DW'(i)) begin
            errors++; $display("FAIL capture_write[%0d]: got en/we %b addr %0d data %0d expected 11 addr %0d data %0d", i, {bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata, i, i);
         end
         step();
      end
      bus.cam_tvalid = 1'b0;
      bus.cam_tuser  = 1'b0;
      checks++;
      if ({ref_valid, capturing} !== 2'b10) begin errors++; $display("FAIL capture_done: got rv/cap %b expected 10", {ref_valid, capturing}); end
      for (int a = 0; a < FR; a++) begin
         checks++;
         if (ram[a] !== DW'(a)) begin errors++; $display("FAIL capture_ram[%0d]: got %0d expected %0d", a, ram[a], a); end
      end
   endtask

   task automatic test_replay();
      logic [DW-1:0] ed;
      logic eu, el;
      bus.m_ref_tready = 1'b1;
      enable = 1'b1;
      step();
      checks++;
      if (bus.m_ref_tvalid !== 1'b0) begin errors++; $display("FAIL replay_latency_c0: got tvalid %b expected 0", bus.m_ref_tvalid); end
      step();
      checks++;
      if (bus.m_ref_tvalid !== 1'b0) begin errors++; $display("FAIL replay_latency_c1: got tvalid %b expected 0", bus.m_ref_tvalid); end
      step();
      for (int k = 0; k < 2 * FR; k++) begin
         ed = DW'(k % FR); eu = (k % FR) == 0; el = (k % HR) == HR - 1;
         checks++;
         if (bus.m_ref_tvalid !== 1'b1 || bus.m_ref_tdata !== ed || bus.m_ref_tuser !== eu || bus.m_ref_tlast !== el) begin
            errors++; $display("FAIL replay_pix[%0d]: got v%b d%0d u%b l%b expected v1 d%0d u%b l%b", k, bus.m_ref_tvalid, bus.m_ref_tdata, bus.m_ref_tuser, bus.m_ref_tlast, ed, eu, el);
         end
         step();
      end
      exp_idx = 2 * FR;
   endtask

   task automatic test_random_tready();
      int acc = 0;
      int cyc = 0;
      logic held = 1'b0;
      logic [DW+1:0] held_val = '0;
      logic [DW-1:0] ed;
      logic eu, el;
      while (acc < 2 * FR && cyc < 400) begin
         if (held) begin
            checks++;
            if (bus.m_ref_tvalid !== 1'b1 || {bus.m_ref_tdata, bus.m_ref_tuser, bus.m_ref_tlast} !== held_val) begin
               errors++; $display("FAIL stall_stable: got v%b %h expected v1 %h", bus.m_ref_tvalid, {bus.m_ref_tdata, bus.m_ref_tuser, bus.m_ref_tlast}, held_val);
            end
         end
         bus.m_ref_tready = 1'($urandom_range(0, 1));
         held = 1'b0;
         if (bus.m_ref_tvalid === 1'b1) begin
            if (bus.m_ref_tready) begin
               ed = DW'(exp_idx % FR); eu = (exp_idx % FR) == 0; el = (exp_idx % HR) == HR - 1;
               checks++;
               if (bus.m_ref_tdata !== ed || bus.m_ref_tuser !== eu || bus.m_ref_tlast !== el) begin
                  errors++; $display("FAIL random_pix[%0d]: got d%0d u%b l%b expected d%0d u%b l%b", exp_idx, bus.m_ref_tdata, bus.m_ref_tuser, bus.m_ref_tlast, ed, eu, el);
               end
               acc++;
               exp_idx++;
            end else begin
               held = 1'b1;
               held_val = {bus.m_ref_tdata, bus.m_ref_tuser, bus.m_ref_tlast};
            end
         end
         step();
         cyc++;
      end
      checks++;
      if (acc != 2 * FR) begin errors++; $display("FAIL random_timeout: got %0d pixels expected %0d", acc, 2 * FR); end
      bus.m_ref_tready = 1'b1;
   endtask

   task automatic test_capture_midstream();
      int cyc = 0;
      logic req_done = 1'b0;
      logic done = 1'b0;
      logic [DW-1:0] ed;
      logic eu, el;
      bus.m_ref_tready = 1'b1;
      while (!done && cyc < 60) begin
         if (bus.m_ref_tvalid === 1'b1) begin
            ed = DW'(exp_idx % FR); eu = (exp_idx % FR) == 0; el = (exp_idx % HR) == HR - 1;
            checks++;
            if (bus.m_ref_tdata !== ed || bus.m_ref_tuser !== eu || bus.m_ref_tlast !== el) begin
               errors++; $display("FAIL midreq_pix[%0d]: got d%0d u%b l%b expected d%0d u%b l%b", exp_idx, bus.m_ref_tdata, bus.m_ref_tuser, bus.m_ref_tlast, ed, eu, el);
            end
            if (!req_done && (exp_idx % FR) == 5) begin capture_req = 1'b1; req_done = 1'b1; end
            else if (req_done && (exp_idx % FR) == FR - 1) done = 1'b1;
            exp_idx++;
         end
         step();
         capture_req = 1'b0;
         cyc++;
      end
      checks++;
      if (!done) begin errors++; $display("FAIL midreq_timeout: got frame end %b expected 1", done); end
      checks++;
      if ({bus.m_ref_tvalid, capturing, ref_valid} !== 3'b010) begin
         errors++; $display("FAIL midreq_wait_sof: got tv/cap/rv %b expected 010", {bus.m_ref_tvalid, capturing, ref_valid});
      end
      step();
      checks++;
      if (bus.m_ref_tvalid !== 1'b0) begin errors++; $display("FAIL midreq_quiet: got tvalid %b expected 0", bus.m_ref_tvalid); end
      for (int i = 0; i < FR; i++) begin
         drive_cam(DW'(100 + i), i == 0);
         #1;
         checks++;
         if (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(i)) begin
            errors++; $display("FAIL recapture_write[%0d]: got we %b addr %0d expected 1 addr %0d", i, bus.mem_we, bus.mem_addr, i);
         end
         step();
      end
      bus.cam_tvalid = 1'b0;
      bus.cam_tuser  = 1'b0;
      checks++;
      if ({ref_valid, capturing, bus.m_ref_tvalid} !== 3'b100) begin
         errors++; $display("FAIL recapture_done: got rv/cap/tv %b expected 100", {ref_valid, capturing, bus.m_ref_tvalid});
      end
      step();
      step();
      for (int k = 0; k < FR; k++) begin
         ed = DW'(100 + k); eu = k == 0; el = (k % HR) == HR - 1;
         checks++;
         if (bus.m_ref_tvalid !== 1'b1 || bus.m_ref_tdata !== ed || bus.m_ref_tuser !== eu || bus.m_ref_tlast !== el) begin
            errors++; $display("FAIL recapture_pix[%0d]: got v%b d%0d u%b l%b expected v1 d%0d u%b l%b", k, bus.m_ref_tvalid, bus.m_ref_tdata, bus.m_ref_tuser, bus.m_ref_tlast, ed, eu, el);
         end
         step();
      end
   endtask

   task automatic test_short_frame();
      int cyc = 0;
      logic [DW-1:0] v;
      int ea;
      capture_req = 1'b1;
      enable = 1'b0;
      step();
      capture_req = 1'b0;
      while (capturing !== 1'b1 && cyc < 40) begin step(); cyc++; end
      checks++;
      if (capturing !== 1'b1) begin errors++; $display("FAIL short_wait_sof: got capturing %b expected 1", capturing); end
      for (int i = 0; i < 19; i++) begin
         v  = (i < 7) ? DW'(i) : DW'(50 + i - 7);
         ea = (i < 7) ? i : i - 7;
         if (i == 18) begin
            checks++;
            if (ref_valid !== 1'b0) begin errors++; $display("FAIL short_ref_valid_early: got %b expected 0", ref_valid); end
         end
         drive_cam(v, (i == 0) || (i == 7));
         #1;
         checks++;
         if (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(ea) || bus.mem_wdata !== v) begin
            errors++; $display("FAIL short_write[%0d]: got we %b addr %0d data %0d expected 1 addr %0d data %0d", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, ea, v);
         end
         step();
      end
      bus.cam_tvalid = 1'b0;
      bus.cam_tuser  = 1'b0;
      checks++;
      if ({ref_valid, capturing} !== 2'b10) begin errors++; $display("FAIL short_done: got rv/cap %b expected 10", {ref_valid, capturing}); end
      for (int a = 0; a < FR; a++) begin
         checks++;
         if (ram[a] !== DW'(50 + a)) begin errors++; $display("FAIL short_ram[%0d]: got %0d expected %0d", a, ram[a], 50 + a); end
      end
   endtask

   task automatic test_reset_midreplay();
      logic [DW-1:0] ed;
      enable = 1'b1;
      bus.m_ref_tready = 1'b1;
      step();
      step();
      step();
      for (int k = 0; k < 6; k++) begin
         ed = DW'(50 + k);
         checks++;
         if (bus.m_ref_tvalid !== 1'b1 || bus.m_ref_tdata !== ed) begin
            errors++; $display("FAIL prereset_pix[%0d]: got v%b d%0d expected v1 d%0d", k, bus.m_ref_tvalid, bus.m_ref_tdata, ed);
         end
         step();
      end
      checks++;
      if (bus.m_ref_tdata !== 16'd56) begin errors++; $display("FAIL prereset_pix6: got %0d expected 56", bus.m_ref_tdata); end
      #2;
      aresetn = 1'b0;
      #1;
      checks++;
      if ({bus.m_ref_tvalid, bus.m_ref_tuser, bus.m_ref_tlast, ref_valid, capturing} !== 5'b0) begin
         errors++; $display("FAIL async_reset_flags: got %b expected 00000", {bus.m_ref_tvalid, bus.m_ref_tuser, bus.m_ref_tlast, ref_valid, capturing});
      end
      checks++;
      if (bus.m_ref_tdata !== 16'h0 || {bus.mem_en, bus.mem_we} !== 2'b00 || bus.mem_addr !== 4'h0) begin
         errors++; $display("FAIL async_reset_data: got d%h en/we %b addr %h expected 0 00 0", bus.m_ref_tdata, {bus.mem_en, bus.mem_we}, bus.mem_addr);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if ({bus.m_ref_tvalid, ref_valid, bus.mem_en} !== 3'b000) begin
            errors++; $display("FAIL post_reset_idle[%0d]: got tv/rv/en %b expected 000", c, {bus.m_ref_tvalid, ref_valid, bus.mem_en});
         end
      end
   endtask

   initial begin
      bus.cam_tdata    = '0;
      bus.cam_tvalid   = 1'b0;
      bus.cam_tready   = 1'b0;
      bus.cam_tuser    = 1'b0;
      bus.m_ref_tready = 1'b0;
      test_reset();
      test_capture();
      test_replay();
      test_random_tready();
      test_capture_midstream();
      test_short_frame();
      test_reset_midreplay();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
